spi_slave: RTL and testbench

//  SPI responder (target): the far end of an SPI link driven by the team's SPI master.

---
 rtl/spi_pkg.sv | 29 ++
 rtl/spi_sync.sv | 33 +++
 rtl/spi_slave.sv | 171 +++++++++++++++++
 tb/tb_spi_slave.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and mode helpers for the SPI responder.
// Mode encoding is {CPOL,CPHA}, identical to the SPI master.
package spi_pkg;

   typedef logic [1:0] spi_mode_t;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } spi_slave_state_t;

   function automatic logic cpol_of(spi_mode_t m);
      return m[1];
   endfunction

   function automatic logic cpha_of(spi_mode_t m);
      return m[0];
   endfunction

   // Leading edge leaves the idle level: rise when CPOL=0, fall when CPOL=1.
   function automatic logic lead_edge(spi_mode_t m, logic rise, logic fall);
      return m[1] ? fall : rise;
   endfunction

   function automatic logic trail_edge(spi_mode_t m, logic rise, logic fall);
      return m[1] ? rise : fall;
   endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer with single-cycle rise/fall pulses
// derived from the last two synchronized samples.
module spi_sync #(
   parameter int   STAGES = 2,
   parameter logic INIT   = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sr;
   logic              q_d;
   logic              q;

   assign q = sr[STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr  <= {STAGES{INIT}};
         q_d <= INIT;
      end else begin
         sr  <= {sr[STAGES-2:0], d};
         q_d <= q;
      end
   end

   assign rise = q & ~q_d;
   assign fall = ~q & q_d;

endmodule

// File: rtl/spi_slave.sv
// SPI responder: oversampled sclk/ss_n/mosi, MSB-first words on valid/ready.
// Optional rx_overrun port enabled by defining SPI_SLAVE_OVERRUN_EN.
module spi_slave
   import spi_pkg::*;
#(
   parameter spi_mode_t SPI_MODE    = 2'd0,
   parameter int        DATA_WIDTH  = 8,
   parameter int        SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sclk,
   input  logic                  ss_n,
   input  logic                  mosi,
   output logic                  miso,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   input  logic                  rx_ready,
   output logic                  busy
`ifdef SPI_SLAVE_OVERRUN_EN
   ,
   output logic                  rx_overrun
`endif
);

   localparam int   CW   = $clog2(DATA_WIDTH + 1);
   localparam logic CPHA = cpha_of(SPI_MODE);

   spi_slave_state_t state, state_nx;

   logic sclk_rise, sclk_fall;
   logic ss_rise, ss_fall;
   logic [SYNC_STAGES-1:0] mosi_sr;
   logic mosi_s;

   logic lead, trail;
   logic sample_edge, shift_edge;
   logic active, start, stop;
   logic do_sample, do_shift, word_done, reload;

   logic [DATA_WIDTH-1:0] hold_data;
   logic                  hold_full;
   logic [DATA_WIDTH-1:0] tx_shift;
   logic [DATA_WIDTH-1:0] rx_shift;
   logic [DATA_WIDTH-1:0] rx_next;
   logic [CW-1:0]         bit_cnt;
   logic                  skip;

   spi_sync #(
      .STAGES(SYNC_STAGES),
      .INIT  (cpol_of(SPI_MODE))
   ) u_sclk_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (sclk),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   spi_sync #(
      .STAGES(SYNC_STAGES),
      .INIT  (1'b1)
   ) u_ss_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (ss_n),
      .rise (ss_rise),
      .fall (ss_fall)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mosi_sr <= '0;
      else        mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
   end

   assign mosi_s = mosi_sr[SYNC_STAGES-1];

   assign lead        = lead_edge(SPI_MODE, sclk_rise, sclk_fall);
   assign trail       = trail_edge(SPI_MODE, sclk_rise, sclk_fall);
   assign sample_edge = CPHA ? trail : lead;
   assign shift_edge  = CPHA ? lead : trail;

   assign active    = (state == ACTIVE);
   assign start     = (state == IDLE) && ss_fall;
   assign stop      = active && ss_rise;
   assign do_sample = active && sample_edge && !ss_rise;
   assign do_shift  = active && shift_edge && !skip;
   assign word_done = do_sample && (bit_cnt == CW'(DATA_WIDTH - 1));
   assign reload    = start || word_done;
   assign rx_next   = {rx_shift[DATA_WIDTH-2:0], mosi_s};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (ss_fall) state_nx = ACTIVE;
         ACTIVE:  if (ss_rise) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_data <= '0;
         hold_full <= 1'b0;
         tx_shift  <= '0;
         rx_shift  <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         bit_cnt   <= '0;
         skip      <= 1'b0;
      end else begin
         // A reload drains the holding reg before a new word can enter it.
         if (reload && hold_full) begin
            hold_full <= 1'b0;
         end else if (tx_valid && !hold_full) begin
            hold_full <= 1'b1;
            hold_data <= tx_data;
         end

         if (reload) begin
            tx_shift <= hold_full ? hold_data : '0;
         end else if (do_shift) begin
            tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
         end

         // The first shift edge after a fresh load must keep the MSB on the line.
         if (start) begin
            skip <= CPHA;
         end else if (word_done) begin
            skip <= 1'b1;
         end else if (active && shift_edge) begin
            skip <= 1'b0;
         end

         if (start || stop) begin
            bit_cnt <= '0;
         end else if (do_sample) begin
            bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
         end

         if (do_sample) rx_shift <= rx_next;

         if (word_done) begin
            rx_data  <= rx_next;
            rx_valid <= 1'b1;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

`ifdef SPI_SLAVE_OVERRUN_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rx_overrun <= 1'b0;
      else        rx_overrun <= word_done && rx_valid && !rx_ready;
   end
`endif

   assign miso     = active ? tx_shift[DATA_WIDTH-1] : 1'b0;
   assign tx_ready = !hold_full;
   assign busy     = active;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one instance per SPI mode, bit-banged master,
// queue scoreboard for rx words, per-word checks of miso data.
module tb_spi_slave;

   localparam int SYNC = 2;
   localparam int HALF = 4;

   typedef struct {
      int         m;
      logic [7:0] d;
   } rx_exp_t;

   logic       clk;
   logic       rst_n;
   logic [3:0] sclk;
   logic [3:0] ss_n;
   logic       mosi;
   logic [3:0] miso;
   logic [7:0] tx_data;
   logic [3:0] tx_valid;
   logic [3:0] tx_ready;
   logic [7:0] rx_data [4];
   logic [3:0] rx_valid;
   logic [3:0] rx_ready;
   logic [3:0] busy;
`ifdef SPI_SLAVE_OVERRUN_EN
   logic [3:0] rx_overrun;
   int         ovr_cnt [4];
`endif

   int tests = 0;
   int fails = 0;

   logic [7:0] exp_tx[$];
   rx_exp_t    exp_rx[$];

   for (genvar g = 0; g < 4; g++) begin : g_dut
      spi_slave #(
         .SPI_MODE   (2'(g)),
         .DATA_WIDTH (8),
         .SYNC_STAGES(SYNC)
      ) u_dut (
         .clk     (clk),
         .rst_n   (rst_n),
         .sclk    (sclk[g]),
         .ss_n    (ss_n[g]),
         .mosi    (mosi),
         .miso    (miso[g]),
         .tx_data (tx_data),
         .tx_valid(tx_valid[g]),
         .tx_ready(tx_ready[g]),
         .rx_data (rx_data[g]),
         .rx_valid(rx_valid[g]),
         .rx_ready(rx_ready[g]),
         .busy    (busy[g])
`ifdef SPI_SLAVE_OVERRUN_EN
         ,
         .rx_overrun(rx_overrun[g])
`endif
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every accepted rx word must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 4; i++) begin
            if (rx_valid[i] && rx_ready[i]) begin
               if (exp_rx.size() == 0) begin
                  check("rx_unexpected", {24'd0, rx_data[i]}, 32'hFFFF_FFFF);
               end else begin
                  rx_exp_t e;
                  e = exp_rx.pop_front();
                  check("rx_instance", i, e.m);
                  check("rx_word", {24'd0, rx_data[i]}, {24'd0, e.d});
               end
            end
`ifdef SPI_SLAVE_OVERRUN_EN
            if (rx_overrun[i]) ovr_cnt[i]++;
`endif
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic load_tx(input int m, input logic [7:0] v);
      int n;
      n = 0;
      while (!tx_ready[m] && n < 200) begin
         tick(1);
         n++;
      end
      check("tx_ready_wait", {31'd0, tx_ready[m]}, 32'd1);
      tx_data     = v;
      tx_valid[m] = 1'b1;
      exp_tx.push_back(v);
      tick(1);
      tx_valid[m] = 1'b0;
      check("tx_ready_full", {31'd0, tx_ready[m]}, 32'd0);
   endtask

   // Master view: a word delivers the oldest loaded tx word, or zeros on underrun.
   task automatic spi_word(input int m, input logic [7:0] mo, input int nbits,
                           input bit push, output logic [7:0] mi);
      logic       cpol, cpha;
      logic [7:0] em;
      rx_exp_t    e;
      cpol = (m >= 2);
      cpha = (m % 2 == 1);
      mi   = '0;
      em   = '0;
      if (nbits == 8) begin
         if (exp_tx.size() != 0) em = exp_tx.pop_front();
         if (push) begin
            e.m = m;
            e.d = mo;
            exp_rx.push_back(e);
         end
      end
      for (int i = 0; i < nbits; i++) begin
         if (!cpha) begin
            mosi = mo[7-i];
            tick(HALF);
            mi = {mi[6:0], miso[m]};
            sclk[m] = ~cpol;
            tick(HALF);
            sclk[m] = cpol;
         end else begin
            tick(HALF);
            sclk[m] = ~cpol;
            mosi = mo[7-i];
            tick(HALF);
            mi = {mi[6:0], miso[m]};
            sclk[m] = cpol;
         end
      end
      if (nbits == 8) check("miso_word", {24'd0, mi}, {24'd0, em});
   endtask

   task automatic frame(input int m, input int nw, input logic [7:0] mo0,
                        input logic [7:0] mo1, input bit load2,
                        input logic [7:0] tx2, input bit push);
      logic [7:0] mi0, mi1;
      ss_n[m] = 1'b0;
      tick(SYNC + 3);
      check("busy_in_frame", {31'd0, busy[m]}, 32'd1);
      fork
         spi_word(m, mo0, 8, push, mi0);
         begin
            if (load2) begin
               tick(8);
               load_tx(m, tx2);
            end
         end
      join
      if (nw > 1) spi_word(m, mo1, 8, push, mi1);
      tick(HALF);
      ss_n[m] = 1'b1;
      tick(8);
      check("busy_after_frame", {31'd0, busy[m]}, 32'd0);
   endtask

   task automatic check_reset(input int m);
      check("rst_miso", {31'd0, miso[m]}, 32'd0);
      check("rst_tx_ready", {31'd0, tx_ready[m]}, 32'd1);
      check("rst_rx_valid", {31'd0, rx_valid[m]}, 32'd0);
      check("rst_rx_data", {24'd0, rx_data[m]}, 32'd0);
      check("rst_busy", {31'd0, busy[m]}, 32'd0);
`ifdef SPI_SLAVE_OVERRUN_EN
      check("rst_overrun", {31'd0, rx_overrun[m]}, 32'd0);
`endif
   endtask

   initial begin
      logic [7:0] mi;
      logic [7:0] a, b;
      int         n;

      rst_n    = 1'b0;
      sclk     = 4'b1100;
      ss_n     = 4'hF;
      mosi     = 1'b0;
      tx_data  = '0;
      tx_valid = '0;
      rx_ready = 4'hF;
`ifdef SPI_SLAVE_OVERRUN_EN
      for (int i = 0; i < 4; i++) ovr_cnt[i] = 0;
`endif
      tick(3);
      for (int i = 0; i < 4; i++) check_reset(i);
      rst_n = 1'b1;
      tick(3);

      // Mode 0 basic exchange
      load_tx(0, 8'hA5);
      frame(0, 1, 8'h3C, 8'h00, 1'b0, 8'h00, 1'b1);
      check("tx_ready_after", {31'd0, tx_ready[0]}, 32'd1);

      // Remaining modes
      for (int m = 1; m < 4; m++) begin
         load_tx(m, 8'h81);
         frame(m, 1, 8'h7E, 8'h00, 1'b0, 8'h00, 1'b1);
      end

      // Back-to-back words with ss_n held low, in every mode
      for (int m = 0; m < 4; m++) begin
         load_tx(m, 8'h11);
         frame(m, 2, 8'hC1, 8'h5D, 1'b1, 8'h22, 1'b1);
      end

      // Underrun, then an aborted partial word
      frame(0, 1, 8'h99, 8'h00, 1'b0, 8'h00, 1'b1);
      ss_n[0] = 1'b0;
      tick(SYNC + 3);
      spi_word(0, 8'hE7, 3, 1'b0, mi);
      tick(HALF);
      ss_n[0] = 1'b1;
      tick(8);
      check("abort_busy", {31'd0, busy[0]}, 32'd0);
      check("abort_rx_valid", {31'd0, rx_valid[0]}, 32'd0);

      // Randomized frames across modes
      for (int k = 0; k < 12; k++) begin
         int m;
         m = k % 4;
         a = 8'($urandom);
         b = 8'($urandom);
         if ($urandom_range(0, 3) != 0) load_tx(m, a);
         frame(m, 1, b, 8'h00, 1'b0, 8'h00, 1'b1);
      end

      // Overwrite while the consumer stalls
      rx_ready[1] = 1'b0;
      frame(1, 2, 8'h4B, 8'hB4, 1'b0, 8'h00, 1'b0);
      check("ovw_rx_valid", {31'd0, rx_valid[1]}, 32'd1);
      check("ovw_rx_data", {24'd0, rx_data[1]}, 32'h0000_00B4);
`ifdef SPI_SLAVE_OVERRUN_EN
      check("overrun_pulses", ovr_cnt[1], 32'd1);
`endif
      begin
         rx_exp_t e;
         e.m = 1;
         e.d = 8'hB4;
         exp_rx.push_back(e);
      end
      rx_ready[1] = 1'b1;
      tick(3);
      check("ovw_drained", {31'd0, rx_valid[1]}, 32'd0);

      // Reset in the middle of a word
      ss_n[0] = 1'b0;
      tick(SYNC + 3);
      spi_word(0, 8'hC3, 3, 1'b0, mi);
      tick(1);
      rst_n = 1'b0;
      #1;
      check_reset(0);
      ss_n[0] = 1'b1;
      sclk[0] = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(4);
      load_tx(0, 8'h96);
      frame(0, 1, 8'h5A, 8'h00, 1'b0, 8'h00, 1'b1);

      n = 0;
      while (exp_rx.size() != 0 && n < 100) begin
         tick(1);
         n++;
      end
      check("scoreboard_drained", exp_rx.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
